// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between the UART receive stage and its consumer.
//   rx        serial line into the receiver (idle high)
//   rd_en     consumer pops the FIFO head
//   clr_err   consumer clears the sticky error flags
//   rd_data   FIFO head byte, valid while rx_empty is 0
//   rx_empty  FIFO holds no bytes
//   rx_full   FIFO is at capacity
//   frame_err sticky: a stop bit was sampled low
//   overrun   sticky: a good byte was dropped because the FIFO was full
// master = consumer/line side, slave = uart_rx.
interface uart_rx_if;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx, rd_en, clr_err,
    input  rd_data, rx_empty, rx_full, frame_err, overrun
  );

  modport slave (
    input  rx, rd_en, clr_err,
    output rd_data, rx_empty, rx_full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// The pin is double-flopped, a falling edge starts a frame, the start bit is
// re-checked at mid-bit and data/stop bits are sampled at mid-bit spacing.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if.slave (rx, rd_en, clr_err in; rd_data, rx_empty,
//          rx_full, frame_err, overrun out)
// Parameters: CLKS_PER_BIT (even, >= 4), FIFO_AW (depth = 2**FIFO_AW).
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Pin synchronizer; all three flops reset to the idle (high) level so
  // reset release never looks like a falling edge.
  logic sync1_reg, rx_s_reg, rx_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= bus.rx;
      rx_s_reg    <= sync1_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  // Frame FSM
  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            stop_good, stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Edge-triggered: a line stuck low cannot restart a frame.
        if (rx_prev_reg && !rx_s_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          if (!rx_s_reg) begin
            state_next = DATA;
            cnt_next   = '0;
            bit_next   = '0;
          end else begin
            state_next = IDLE;   // start bit vanished: glitch
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          shift_next[bit_reg] = rx_s_reg;
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          stop_good  = rx_s_reg;
          stop_bad   = !rx_s_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO: storage is registered, head is read combinationally (FWFT).
  logic [7:0]       mem_reg [DEPTH];
  logic [FIFO_AW-1:0] wptr_reg, rptr_reg;
  logic [FIFO_AW:0] count_reg;
  logic [DEPTH-1:0] we;
  logic             empty, full, pop, push, overrun_set;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign pop   = bus.rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push        = stop_good && (!full || pop);
  assign overrun_set = stop_good && full && !pop;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign we[gi] = push && (wptr_reg == FIFO_AW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) mem_reg[i] <= shift_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (pop)  rptr_reg <= rptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  logic frame_err_reg, overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (stop_bad)         frame_err_reg <= 1'b1;
      else if (bus.clr_err) frame_err_reg <= 1'b0;
      if (overrun_set)      overrun_reg <= 1'b1;
      else if (bus.clr_err) overrun_reg <= 1'b0;
    end
  end

  assign bus.rd_data   = mem_reg[rptr_reg];
  assign bus.rx_empty  = empty;
  assign bus.rx_full   = full;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios plus randomized frames for uart_rx, checked
// against a queue-based model of the received-byte stream and error flags.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes the consumer should see, and sticky flags.
  logic [7:0] q[$];
  logic       fe_m = 1'b0;
  logic       ov_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame; caller starts it right after a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    $display("tx frame byte=0x%02h stop=%0b", b, stop_bit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  // A completed frame as seen from outside: bad stop -> framing error,
  // good byte with no room -> overrun, otherwise appended.
  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit)             fe_m = 1'b1;
    else if (q.size() == DEPTH) ov_m = 1'b1;
    else                        q.push_back(b);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_empty"}, 32'(bus.rx_empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(bus.rx_full),  32'(q.size() == DEPTH));
    if (q.size() > 0) chk({tag, "_data"}, 32'(bus.rd_data), 32'(q[0]));
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'(fe_m));
    chk({tag, "_overrun"},   32'(bus.overrun),   32'(ov_m));
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] head;
    head = q.pop_front();
    chk({tag, "_pop_data"}, 32'(bus.rd_data), 32'(head));
    $display("rd byte=0x%02h", bus.rd_data);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    fe_m = 1'b0;
    ov_m = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       sb;
    int         npop;

    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check_state("reset");
    chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Single byte with exact latency: visible on posedge 155 after the
    // pin drive (2 sync edges put rx_s low at cycle 0, byte at cycle 153).
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 chk("single_before_153_empty", 32'(bus.rx_empty), 32'h1);
        @(posedge clk);
        #1 chk("single_at_153_empty", 32'(bus.rx_empty), 32'h0);
        chk("single_at_153_data", 32'(bus.rd_data), 32'hA5);
      end
    join
    model_frame(8'hA5, 1'b1);
    idle(2);
    check_state("single");
    pop_one("single");
    check_state("single_after_pop");

    // Glitch rejection
    bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    idle(40);
    check_state("glitch");

    // Framing error, clear, then a clean frame
    send_frame(8'h3C, 1'b0);
    idle(4);
    model_frame(8'h3C, 1'b0);
    check_state("frame_err");
    clear_err();
    check_state("frame_err_cleared");
    send_frame(8'h3C, 1'b1);
    idle(2);
    model_frame(8'h3C, 1'b1);
    check_state("frame_ok");
    pop_one("frame_ok");

    // Overrun with back-to-back frames
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1);
      model_frame(8'(k), 1'b1);
    end
    idle(4);
    check_state("overrun");
    for (int k = 0; k < 4; k++) pop_one("overrun_drain");
    check_state("overrun_drained");
    clear_err();
    check_state("overrun_cleared");

    // Full FIFO with a pop exactly in the fifth byte's stop-sample cycle
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k), 1'b1);
      model_frame(8'h10 + 8'(k), 1'b1);
    end
    idle(4);
    check_state("full4");
    fork
      send_frame(8'h14, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        pop_one("full_pop_at_stop");
      end
    join
    model_frame(8'h14, 1'b1);
    idle(2);
    check_state("full_pop_at_stop");
    for (int k = 0; k < 4; k++) pop_one("full_drain");
    check_state("full_drained");

    // Reset in the middle of a frame, with state present beforehand
    send_frame(8'h77, 1'b1);
    model_frame(8'h77, 1'b1);
    send_frame(8'h00, 1'b0);
    model_frame(8'h00, 1'b0);
    idle(4);
    check_state("pre_reset");
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(88);
        rst_n = 1'b0;
        #1;
        q.delete();
        fe_m = 1'b0;
        ov_m = 1'b0;
        check_state("mid_reset");
        chk("mid_reset_rd_data", 32'(bus.rd_data), 32'h0);
        idle(2);
        rst_n = 1'b1;
      end
    join
    idle(4);
    check_state("post_reset_idle");
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    idle(2);
    check_state("post_reset_rx");
    pop_one("post_reset");
    check_state("post_reset_empty");

    // Randomized frames, stop-bit errors, pops and clears
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      send_frame(b, sb);
      idle(4);
      model_frame(b, sb);
      check_state("rand_rx");
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (q.size() > 0) pop_one("rand");
      end
      if ($urandom_range(0, 3) == 0) clear_err();
      check_state("rand_after");
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
